// File: rtl/noc_pkg.sv
// Shared types and defaults for the NoC round-robin crossbar.
package noc_pkg;

    localparam int unsigned DefRadixIn   = 4;
    localparam int unsigned DefRadixOut  = 4;
    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefDepth     = 4;

    // Width of the destination field taken from the low address bits.
    function automatic int unsigned dest_w(input int unsigned radix_out);
        return (radix_out > 1) ? $clog2(radix_out) : 1;
    endfunction

    typedef enum logic {
        IDLE,
        LOCKED
    } xbar_state_e;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter for one crossbar output; can be pinned to a single owner.
module noc_rr_arbiter #(
    parameter int unsigned RADIX_IN = 4
) (
    input  logic [RADIX_IN-1:0]         req,
    input  logic [$clog2(RADIX_IN)-1:0] ptr,
    input  logic                        en,
    input  logic                        hold,
    input  logic [$clog2(RADIX_IN)-1:0] hold_idx,
    output logic [RADIX_IN-1:0]         grant,
    output logic [$clog2(RADIX_IN)-1:0] next_ptr
);

    localparam int unsigned IW = $clog2(RADIX_IN);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        if (en) begin
            if (hold) begin
                // Pinned: only the owner may go, and the pointer stays frozen.
                if (req[hold_idx]) begin
                    grant[hold_idx] = 1'b1;
                end
            end else begin
                for (int k = 0; k < int'(RADIX_IN); k++) begin
                    idx = (int'(ptr) + k) % int'(RADIX_IN);
                    if (!found && req[idx]) begin
                        found      = 1'b1;
                        grant[idx] = 1'b1;
                        next_ptr   = IW'((idx + 1) % int'(RADIX_IN));
                    end
                end
            end
        end
    end

endmodule

// File: rtl/noc_rr_crossbar.sv
// Buffered NoC crossbar: per-input flit FIFOs, address routing, per-output
// round-robin arbitration with downstream backpressure and optional wormhole locking.
module noc_rr_crossbar
    import noc_pkg::*;
#(
    parameter int unsigned RADIX_IN    = DefRadixIn,
    parameter int unsigned RADIX_OUT   = DefRadixOut,
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned PACKET_MODE = 0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [RADIX_IN-1:0]                            fifo_enq,
    input  logic [RADIX_IN-1:0][ADDR_WIDTH+DATA_WIDTH-1:0] fifo_in,
    input  logic [RADIX_IN-1:0]                            fifo_last,
    output logic [RADIX_IN-1:0]                            fifo_full,
    output logic [RADIX_IN-1:0]                            fifo_overflow,
    output logic [RADIX_IN-1:0]                            route_err,
    output logic [RADIX_OUT-1:0]                           fifo_enq_downstream,
    output logic [RADIX_OUT-1:0][ADDR_WIDTH+DATA_WIDTH-1:0] fifo_out,
    output logic [RADIX_OUT-1:0]                           fifo_last_out,
    input  logic [RADIX_OUT-1:0]                           fifo_full_downstream
);

    localparam int unsigned FW = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned DW = dest_w(RADIX_OUT);
    localparam int unsigned IW = $clog2(RADIX_IN);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Input FIFO storage: {last, flit}
    logic [FW:0]          mem_q   [RADIX_IN][DEPTH];
    logic [AW-1:0]        head_q  [RADIX_IN];
    logic [AW-1:0]        tail_q  [RADIX_IN];
    logic [CW-1:0]        count_q [RADIX_IN];
    logic [CW-1:0]        count_d [RADIX_IN];
    logic [RADIX_IN-1:0]  full_q, overflow_q, route_err_q;

    logic [RADIX_IN-1:0]  enq_ok, deq, nonempty, illegal, head_last;
    logic [FW-1:0]        head_flit [RADIX_IN];
    logic [DW-1:0]        head_dest [RADIX_IN];

    logic [RADIX_IN-1:0]  req      [RADIX_OUT];
    logic [RADIX_IN-1:0]  grant    [RADIX_OUT];
    logic [IW-1:0]        ptr_q    [RADIX_OUT];
    logic [IW-1:0]        ptr_nxt  [RADIX_OUT];
    logic [IW-1:0]        gidx     [RADIX_OUT];
    logic [IW-1:0]        owner_q  [RADIX_OUT];
    logic [IW-1:0]        owner_d  [RADIX_OUT];
    xbar_state_e          state_q  [RADIX_OUT];
    xbar_state_e          state_d  [RADIX_OUT];
    logic [FW-1:0]        sel_flit [RADIX_OUT];
    logic [RADIX_OUT-1:0] sel_last, any_gnt, hold, arb_en;

    assign fifo_full     = full_q;
    assign fifo_overflow = overflow_q;
    assign route_err     = route_err_q;
    assign arb_en        = ~fifo_full_downstream;

    // Head decode and request matrix; a head matching no output is illegal.
    always_comb begin
        for (int o = 0; o < int'(RADIX_OUT); o++) begin
            req[o] = '0;
        end
        for (int i = 0; i < int'(RADIX_IN); i++) begin
            enq_ok[i]    = fifo_enq[i] & ~full_q[i];
            nonempty[i]  = (count_q[i] != '0);
            head_flit[i] = mem_q[i][head_q[i]][FW-1:0];
            head_last[i] = mem_q[i][head_q[i]][FW];
            head_dest[i] = head_flit[i][DATA_WIDTH +: DW];
            illegal[i]   = nonempty[i];
            for (int o = 0; o < int'(RADIX_OUT); o++) begin
                if (nonempty[i] && (head_dest[i] == DW'(o))) begin
                    req[o][i]  = 1'b1;
                    illegal[i] = 1'b0;
                end
            end
        end
    end

    for (genvar o = 0; o < RADIX_OUT; o++) begin : g_arb
        noc_rr_arbiter #(
            .RADIX_IN(RADIX_IN)
        ) u_arb (
            .req     (req[o]),
            .ptr     (ptr_q[o]),
            .en      (arb_en[o]),
            .hold    (hold[o]),
            .hold_idx(owner_q[o]),
            .grant   (grant[o]),
            .next_ptr(ptr_nxt[o])
        );
    end

    always_comb begin
        deq = illegal;
        for (int o = 0; o < int'(RADIX_OUT); o++) begin
            hold[o]    = (PACKET_MODE != 0) && (state_q[o] == LOCKED);
            any_gnt[o] = |grant[o];
            gidx[o]    = '0;
            for (int i = 0; i < int'(RADIX_IN); i++) begin
                if (grant[o][i]) begin
                    gidx[o] = IW'(i);
                    deq[i]  = 1'b1;
                end
            end
            sel_flit[o] = head_flit[gidx[o]];
            sel_last[o] = head_last[gidx[o]];
            state_d[o]  = state_q[o];
            owner_d[o]  = owner_q[o];
            if ((PACKET_MODE != 0) && any_gnt[o]) begin
                if ((state_q[o] == IDLE) && !sel_last[o]) begin
                    state_d[o] = LOCKED;
                    owner_d[o] = gidx[o];
                end else if ((state_q[o] == LOCKED) && sel_last[o]) begin
                    state_d[o] = IDLE;
                end
            end
        end
        for (int i = 0; i < int'(RADIX_IN); i++) begin
            count_d[i] = count_q[i] + CW'(enq_ok[i]) - CW'(deq[i]);
        end
    end

    // Storage is not reset; validity comes from the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(RADIX_IN); i++) begin
            if (enq_ok[i]) begin
                mem_q[i][tail_q[i]] <= {fifo_last[i], fifo_in[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RADIX_IN); i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            full_q      <= '0;
            overflow_q  <= '0;
            route_err_q <= '0;
        end else begin
            for (int i = 0; i < int'(RADIX_IN); i++) begin
                if (enq_ok[i]) begin
                    tail_q[i] <= tail_q[i] + AW'(1);
                end
                if (deq[i]) begin
                    head_q[i] <= head_q[i] + AW'(1);
                end
                count_q[i] <= count_d[i];
                full_q[i]  <= (count_d[i] == CW'(DEPTH));
                if (fifo_enq[i] && full_q[i]) begin
                    overflow_q[i] <= 1'b1;
                end
                if (illegal[i]) begin
                    route_err_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_enq_downstream <= '0;
            fifo_out            <= '0;
            fifo_last_out       <= '0;
            for (int o = 0; o < int'(RADIX_OUT); o++) begin
                ptr_q[o]   <= '0;
                owner_q[o] <= '0;
                state_q[o] <= IDLE;
            end
        end else begin
            for (int o = 0; o < int'(RADIX_OUT); o++) begin
                fifo_enq_downstream[o] <= any_gnt[o];
                if (any_gnt[o]) begin
                    fifo_out[o]      <= sel_flit[o];
                    fifo_last_out[o] <= sel_last[o];
                end
                ptr_q[o]   <= ptr_nxt[o];
                owner_q[o] <= owner_d[o];
                state_q[o] <= state_d[o];
            end
        end
    end

endmodule

// File: tb/tb_noc_rr_crossbar.sv
// Directed bench: dut_a is per-flit 4x4, dut_b is wormhole 4x3 (exercises illegal routes).
module tb_noc_rr_crossbar;

    localparam int unsigned FW = 36;

    logic clk;
    logic rst;

    logic [3:0]         a_enq, a_last, a_full, a_ovf, a_rerr;
    logic [3:0][FW-1:0] a_in;
    logic [3:0]         a_ds_enq, a_last_out, a_fds;
    logic [3:0][FW-1:0] a_out;

    logic [3:0]         b_enq, b_last, b_full, b_ovf, b_rerr;
    logic [3:0][FW-1:0] b_in;
    logic [2:0]         b_ds_enq, b_last_out, b_fds;
    logic [2:0][FW-1:0] b_out;

    int tests = 0;
    int fails = 0;

    noc_rr_crossbar #(
        .RADIX_IN(4), .RADIX_OUT(4), .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(0)
    ) dut_a (
        .clk(clk), .rst(rst),
        .fifo_enq(a_enq), .fifo_in(a_in), .fifo_last(a_last),
        .fifo_full(a_full), .fifo_overflow(a_ovf), .route_err(a_rerr),
        .fifo_enq_downstream(a_ds_enq), .fifo_out(a_out), .fifo_last_out(a_last_out),
        .fifo_full_downstream(a_fds)
    );

    noc_rr_crossbar #(
        .RADIX_IN(4), .RADIX_OUT(3), .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .fifo_enq(b_enq), .fifo_in(b_in), .fifo_last(b_last),
        .fifo_full(b_full), .fifo_overflow(b_ovf), .route_err(b_rerr),
        .fifo_enq_downstream(b_ds_enq), .fifo_out(b_out), .fifo_last_out(b_last_out),
        .fifo_full_downstream(b_fds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_enq = '0; a_in = '0; a_last = '0; a_fds = '0;
        b_enq = '0; b_in = '0; b_last = '0; b_fds = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_full", a_full, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_rerr", {a_rerr, b_rerr}, 0);
        chk("rst_ds_enq", {a_ds_enq, b_ds_enq}, 0);
        chk("rst_out", |{a_out, b_out}, 0);
        chk("rst_last_out", {a_last_out, b_last_out}, 0);

        // Single flit input 0 -> output 2
        a_in[0] = {4'd2, 32'hA5};
        a_enq[0] = 1'b1;
        step();
        a_enq = '0;
        chk("single_early", a_ds_enq, 0);
        step();
        chk("single_vld", a_ds_enq, 4'b0100);
        chk("single_data", a_out[2], {4'd2, 32'hA5});
        chk("single_other", |{a_out[3], a_out[1], a_out[0]}, 0);
        step();
        chk("single_pulse", a_ds_enq, 0);

        // Contention: two all-request rounds on output 1, both start at input 0
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                a_in[i] = {4'd1, 32'(32'h10 * (r + 1) + i)};
            end
            a_enq = 4'hF;
            step();
            a_enq = '0;
            for (int i = 0; i < 4; i++) begin
                step();
                chk("cont_vld", a_ds_enq, 4'b0010);
                chk("cont_data", a_out[1], {4'd1, 32'(32'h10 * (r + 1) + i)});
            end
            step();
            chk("cont_idle", a_ds_enq, 0);
        end

        // Backpressure on output 3 for 5 cycles, two flits queued on input 1
        a_fds[3] = 1'b1;
        a_in[1] = {4'd3, 32'h31};
        a_enq[1] = 1'b1;
        step();
        chk("bp_hold", a_ds_enq[3], 0);
        a_in[1] = {4'd3, 32'h32};
        step();
        chk("bp_hold", a_ds_enq[3], 0);
        a_enq = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_hold", a_ds_enq[3], 0);
        end
        a_fds[3] = 1'b0;
        step();
        chk("bp_vld1", a_ds_enq, 4'b1000);
        chk("bp_data1", a_out[3], {4'd3, 32'h31});
        step();
        chk("bp_vld2", a_ds_enq, 4'b1000);
        chk("bp_data2", a_out[3], {4'd3, 32'h32});
        step();
        chk("bp_idle", a_ds_enq, 0);

        // Overflow on input 2 while output 2 is blocked
        a_fds[2] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            a_in[2] = {4'd2, 32'(32'h40 + n)};
            a_enq[2] = 1'b1;
            step();
            chk("ovf_full", a_full[2], (n >= 3));
            chk("ovf_sticky", a_ovf[2], (n == 4));
        end
        a_enq = '0;
        a_fds[2] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (n == 0) chk("ovf_full_fall", a_full[2], 0);
            chk("ovf_vld", a_ds_enq, 4'b0100);
            chk("ovf_data", a_out[2], {4'd2, 32'(32'h40 + n)});
        end
        step();
        chk("ovf_dropped", a_ds_enq, 0);
        chk("ovf_kept", a_ovf[2], 1);

        // Wormhole: 3-flit packet on input 0 holds output 0 over input 1
        b_fds[0] = 1'b1;
        b_in[0] = {4'd0, 32'h50}; b_last[0] = 1'b0;
        b_in[1] = {4'd0, 32'h60}; b_last[1] = 1'b1;
        b_enq = 4'b0011;
        step();
        b_in[0] = {4'd0, 32'h51}; b_last[0] = 1'b0;
        b_enq = 4'b0001;
        step();
        b_in[0] = {4'd0, 32'h52}; b_last[0] = 1'b1;
        step();
        b_enq = '0;
        b_fds[0] = 1'b0;
        step();
        chk("wh_vld0", b_ds_enq, 3'b001);
        chk("wh_data0", {b_last_out[0], b_out[0]}, {1'b0, 4'd0, 32'h50});
        step();
        chk("wh_vld1", b_ds_enq, 3'b001);
        chk("wh_data1", {b_last_out[0], b_out[0]}, {1'b0, 4'd0, 32'h51});
        step();
        chk("wh_vld2", b_ds_enq, 3'b001);
        chk("wh_data2", {b_last_out[0], b_out[0]}, {1'b1, 4'd0, 32'h52});
        step();
        chk("wh_vld3", b_ds_enq, 3'b001);
        chk("wh_data3", {b_last_out[0], b_out[0]}, {1'b1, 4'd0, 32'h60});
        step();
        chk("wh_idle", b_ds_enq, 0);

        // Illegal destination 3 on a 3-output crossbar is discarded
        b_in[2] = {4'd3, 32'h77}; b_last[2] = 1'b1;
        b_enq = 4'b0100;
        step();
        b_enq = '0;
        chk("rerr_pre", b_rerr, 0);
        step();
        chk("rerr_set", b_rerr, 4'b0100);
        chk("rerr_nofwd", b_ds_enq, 0);
        step();
        chk("rerr_empty", b_ds_enq, 0);

        // Addr 5 routes on its low bits to output 1; upper bit passes through
        b_in[3] = {4'd5, 32'h88}; b_last[3] = 1'b1;
        b_enq = 4'b1000;
        step();
        b_enq = '0;
        step();
        chk("pass_vld", b_ds_enq, 3'b010);
        chk("pass_data", b_out[1], {4'd5, 32'h88});

        // Reset while output 0 of dut_b is locked and flits are buffered
        a_fds[0] = 1'b1;
        a_in[0] = {4'd0, 32'h99}; a_enq[0] = 1'b1;
        b_in[0] = {4'd0, 32'h90}; b_last[0] = 1'b0; b_enq = 4'b0001;
        step();
        a_enq = '0;
        b_enq = '0;
        step();
        chk("lock_vld", b_ds_enq, 3'b001);
        b_in[1] = {4'd0, 32'h91}; b_last[1] = 1'b1; b_enq = 4'b0010;
        step();
        b_enq = '0;
        step();
        chk("lock_block", b_ds_enq, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out", b_out[0], 0);
        chk("arst_all", |{a_out, b_out, a_ds_enq, b_ds_enq, a_last_out, b_last_out}, 0);
        chk("arst_flags", {a_full, a_ovf, a_rerr, b_rerr}, 0);
        step();
        rst = 1'b0;
        a_fds[0] = 1'b0;
        b_in[1] = {4'd0, 32'hAB}; b_last[1] = 1'b1; b_enq = 4'b0010;
        step();
        b_enq = '0;
        chk("post_early", {a_ds_enq, b_ds_enq}, 0);
        step();
        chk("post_vld", b_ds_enq, 3'b001);
        chk("post_data", b_out[0], {4'd0, 32'hAB});
        chk("post_a_lost", a_ds_enq, 0);
        step();
        chk("post_b_lost", b_ds_enq, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
